// File: rtl/sat_bin_pkg.sv
// Shared constants, field offsets and FSM encoding for the bin-storage core port.
// The clause evaluator and any future core logic import these definitions.
package sat_bin_pkg;

  localparam int NUM_CLAUSES_A_BIN = 8;
  localparam int NUM_VARS_A_BIN    = 8;
  localparam int NUM_LVLS_A_BIN    = 8;
  localparam int WIDTH_BIN_ID      = 10;
  localparam int WIDTH_LVL         = 16;
  localparam int WIDTH_VAR_STATES  = 19;
  localparam int WIDTH_LVL_STATES  = 11;
  localparam int CLAUSE_W          = 2 * NUM_VARS_A_BIN;
  localparam int IDX_W             = $clog2(NUM_CLAUSES_A_BIN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES_A_BIN - 1);

  localparam logic [1:0] LIT_ABSENT = 2'b00;
  localparam logic [1:0] LIT_NEG    = 2'b01;
  localparam logic [1:0] LIT_POS    = 2'b10;
  localparam logic [1:0] VAL_FREE   = 2'b00;
  localparam logic [1:0] VAL_FALSE  = 2'b01;
  localparam logic [1:0] VAL_TRUE   = 2'b10;

  // var state = {value[1:0], implied, level[15:0]}; lvl state = {dcd_bin[9:0], has_bkt}
  localparam int VS_LEVEL_LSB   = 0;
  localparam int VS_IMPLIED_BIT = 16;
  localparam int VS_VALUE_LSB   = 17;
  localparam int LS_HAS_BKT_BIT = 0;
  localparam int LS_DCD_BIN_LSB = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // 11 is an illegal literal and behaves like an absent one
  function automatic logic lit_present(input logic [1:0] lit);
    return (lit == LIT_NEG) || (lit == LIT_POS);
  endfunction

endpackage

// File: rtl/sat_core_bin_port_clause_eval.sv
// Combinational evaluation of one clause against the current variable values.
// Shared with the full SAT core.
module clause_eval
  import sat_bin_pkg::*;
(
  input  logic [CLAUSE_W-1:0] clause,
  input  logic [CLAUSE_W-1:0] values,
  output logic                is_empty,
  output logic                is_sat,
  output logic                is_unsat
);

  logic       any_present_s;
  logic       any_true_s;
  logic       all_false_s;
  logic [1:0] lit_s;
  logic [1:0] val_s;

  // Fold every literal into present / true / all-false summaries
  always_comb begin
    any_present_s = 1'b0;
    any_true_s    = 1'b0;
    all_false_s   = 1'b1;
    lit_s         = LIT_ABSENT;
    val_s         = VAL_FREE;
    for (int k = 0; k < NUM_VARS_A_BIN; k++) begin
      lit_s = clause[2*k +: 2];
      val_s = values[2*k +: 2];
      if (lit_present(lit_s)) begin
        any_present_s = 1'b1;
        any_true_s    = any_true_s | (lit_s == val_s);
        all_false_s   = all_false_s & (val_s != VAL_FREE) & (lit_s != val_s);
      end else begin
        any_present_s = any_present_s;
      end
    end
  end

  assign is_empty = ~any_present_s;
  assign is_sat   = any_true_s;
  assign is_unsat = any_present_s & all_false_s;

endmodule

// File: rtl/sat_core_bin_port.sv
// Core-side bin storage endpoint: holds one bin of clauses / var states / lvl states
// and, on start, scans the clauses to report local sat / unsat with a done pulse.
module sat_core_bin_port
  import sat_bin_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start_core_i,
  output logic                                         done_core_o,
  input  logic [WIDTH_BIN_ID-1:0]                      cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                         cur_lvl_i,
  output logic                                         local_sat_o,
  output logic                                         local_unsat_o,
  output logic [WIDTH_LVL-1:0]                         cur_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]                      bkt_bin_o,
  output logic [WIDTH_LVL-1:0]                         bkt_lvl_o,
  input  logic [NUM_CLAUSES_A_BIN-1:0]                 wr_carray_i,
  input  logic [NUM_CLAUSES_A_BIN-1:0]                 rd_carray_i,
  input  logic [CLAUSE_W-1:0]                          clause_i,
  output logic [CLAUSE_W-1:0]                          clause_o,
  input  logic [NUM_VARS_A_BIN-1:0]                    wr_var_states_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   vars_states_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   vars_states_o,
  input  logic [NUM_LVLS_A_BIN-1:0]                    wr_lvl_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_o,
  input  logic                                         base_lvl_en_i,
  input  logic [WIDTH_LVL-1:0]                         base_lvl_i,
  output logic [WIDTH_LVL-1:0]                         base_lvl_o
);

  state_e state_r;
  state_e state_nx_s;

  logic [CLAUSE_W-1:0]                        clause_mem_r [NUM_CLAUSES_A_BIN];
  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_r;
  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvls_r;
  logic [CLAUSE_W-1:0]                        clause_rd_r;
  logic [WIDTH_LVL-1:0]                       base_lvl_r;
  logic [WIDTH_LVL-1:0]                       latched_lvl_r;
  logic [WIDTH_BIN_ID-1:0]                    bkt_bin_r;
  logic [IDX_W-1:0]                           idx_r;
  logic                                       sat_acc_r;
  logic                                       unsat_acc_r;
  logic                                       sat_out_r;
  logic                                       unsat_out_r;
  logic                                       done_r;

  logic [CLAUSE_W-1:0] values_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic                rd_hit_s;
  logic                cl_empty_s;
  logic                cl_sat_s;
  logic                cl_unsat_s;
  logic                sat_nx_s;
  logic                unsat_nx_s;

  // Gather the 2-bit value field of every var state into the evaluator's value vector
  always_comb begin
    values_s = '0;
    for (int k = 0; k < NUM_VARS_A_BIN; k++) begin
      values_s[2*k +: 2] = vars_r[k*WIDTH_VAR_STATES + VS_VALUE_LSB +: 2];
    end
  end

  clause_eval u_clause_eval (
    .clause   (clause_mem_r[idx_r]),
    .values   (values_s),
    .is_empty (cl_empty_s),
    .is_sat   (cl_sat_s),
    .is_unsat (cl_unsat_s)
  );

  assign sat_nx_s   = sat_acc_r & (cl_empty_s | cl_sat_s);
  assign unsat_nx_s = unsat_acc_r | (~cl_empty_s & cl_unsat_s);

  // Lowest set read-select bit wins; scanning downward lets lower bits overwrite
  always_comb begin
    rd_hit_s = |rd_carray_i;
    rd_idx_s = '0;
    for (int i = NUM_CLAUSES_A_BIN - 1; i >= 0; i--) begin
      rd_idx_s = rd_carray_i[i] ? IDX_W'(i) : rd_idx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_core_i) begin
          state_nx_s = EVAL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EVAL: begin
        if (idx_r == LAST_IDX) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = EVAL;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Bin storage: writes only land while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLAUSES_A_BIN; i++) begin
        clause_mem_r[i] <= '0;
      end
      vars_r <= '0;
      lvls_r <= '0;
    end else if (state_r == IDLE) begin
      for (int i = 0; i < NUM_CLAUSES_A_BIN; i++) begin
        if (wr_carray_i[i]) clause_mem_r[i] <= clause_i;
      end
      for (int k = 0; k < NUM_VARS_A_BIN; k++) begin
        if (wr_var_states_i[k])
          vars_r[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] <=
            vars_states_i[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
      end
      for (int k = 0; k < NUM_LVLS_A_BIN; k++) begin
        if (wr_lvl_states_i[k])
          lvls_r[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] <=
            lvl_states_i[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
      end
    end
  end

  // Clause read port and base level latch, active in every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clause_rd_r <= '0;
      base_lvl_r  <= '0;
    end else begin
      if (rd_hit_s) clause_rd_r <= clause_mem_r[rd_idx_s];
      if (base_lvl_en_i) base_lvl_r <= base_lvl_i;
    end
  end

  // Scan datapath: start latches, per-clause accumulation, result publish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latched_lvl_r <= '0;
      bkt_bin_r     <= '0;
      idx_r         <= '0;
      sat_acc_r     <= 1'b0;
      unsat_acc_r   <= 1'b0;
      sat_out_r     <= 1'b0;
      unsat_out_r   <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_core_i) begin
            latched_lvl_r <= cur_lvl_i;
            bkt_bin_r     <= cur_bin_num_i;
            idx_r         <= '0;
            sat_acc_r     <= 1'b1;
            unsat_acc_r   <= 1'b0;
            sat_out_r     <= 1'b0;
            unsat_out_r   <= 1'b0;
          end
        end
        EVAL: begin
          sat_acc_r   <= sat_nx_s;
          unsat_acc_r <= unsat_nx_s;
          idx_r       <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            done_r      <= 1'b1;
            sat_out_r   <= sat_nx_s & ~unsat_nx_s;
            unsat_out_r <= unsat_nx_s;
          end
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign done_core_o   = done_r;
  assign local_sat_o   = sat_out_r;
  assign local_unsat_o = unsat_out_r;
  assign cur_lvl_o     = latched_lvl_r;
  assign bkt_lvl_o     = latched_lvl_r;
  assign bkt_bin_o     = bkt_bin_r;
  assign clause_o      = clause_rd_r;
  assign vars_states_o = vars_r;
  assign lvl_states_o  = lvls_r;
  assign base_lvl_o    = base_lvl_r;

endmodule

// File: tb/tb_sat_core_bin_port.sv
// Self-checking bench for sat_core_bin_port: directed scenarios plus randomized bins
// checked against a clause-counting reference model.
module tb_sat_core_bin_port;

  localparam int NC = 8, NV = 8, NL = 8, WB = 10, WL = 16, WV = 19, WLS = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_core_i, done_core_o;
  logic [WB-1:0]     cur_bin_num_i, bkt_bin_o;
  logic [WL-1:0]     cur_lvl_i, cur_lvl_o, bkt_lvl_o, base_lvl_i, base_lvl_o;
  logic              local_sat_o, local_unsat_o, base_lvl_en_i;
  logic [NC-1:0]     wr_carray_i, rd_carray_i;
  logic [2*NV-1:0]   clause_i, clause_o;
  logic [NV-1:0]     wr_var_states_i;
  logic [WV*NV-1:0]  vars_states_i, vars_states_o;
  logic [NL-1:0]     wr_lvl_states_i;
  logic [WLS*NL-1:0] lvl_states_i, lvl_states_o;

  sat_core_bin_port dut (
    .clk(clk), .rst(rst), .start_core_i(start_core_i), .done_core_o(done_core_o),
    .cur_bin_num_i(cur_bin_num_i), .cur_lvl_i(cur_lvl_i),
    .local_sat_o(local_sat_o), .local_unsat_o(local_unsat_o),
    .cur_lvl_o(cur_lvl_o), .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o),
    .wr_carray_i(wr_carray_i), .rd_carray_i(rd_carray_i),
    .clause_i(clause_i), .clause_o(clause_o),
    .wr_var_states_i(wr_var_states_i), .vars_states_i(vars_states_i),
    .vars_states_o(vars_states_o),
    .wr_lvl_states_i(wr_lvl_states_i), .lvl_states_i(lvl_states_i),
    .lvl_states_o(lvl_states_o),
    .base_lvl_en_i(base_lvl_en_i), .base_lvl_i(base_lvl_i), .base_lvl_o(base_lvl_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*NV-1:0] m_clause [NC];
  logic [WV-1:0]   m_var    [NV];
  logic [WLS-1:0]  m_lvl    [NL];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_core_i = 1'b0; cur_bin_num_i = '0; cur_lvl_i = '0;
    wr_carray_i = '0; rd_carray_i = '0; clause_i = '0;
    wr_var_states_i = '0; vars_states_i = '0;
    wr_lvl_states_i = '0; lvl_states_i = '0;
    base_lvl_en_i = 1'b0; base_lvl_i = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_clause[i] = '0;
    for (int i = 0; i < NV; i++) m_var[i] = '0;
    for (int i = 0; i < NL; i++) m_lvl[i] = '0;
  endtask

  task automatic put_clause(input logic [NC-1:0] mask, input logic [2*NV-1:0] data);
    wr_carray_i = mask; clause_i = data;
    tick();
    wr_carray_i = '0;
    for (int i = 0; i < NC; i++) if (mask[i]) m_clause[i] = data;
  endtask

  task automatic put_var(input int k, input logic [WV-1:0] st);
    wr_var_states_i = '0; wr_var_states_i[k] = 1'b1;
    vars_states_i = '0; vars_states_i[k*WV +: WV] = st;
    tick();
    wr_var_states_i = '0;
    m_var[k] = st;
  endtask

  task automatic put_lvl(input int k, input logic [WLS-1:0] st);
    wr_lvl_states_i = '0; wr_lvl_states_i[k] = 1'b1;
    lvl_states_i = '0; lvl_states_i[k*WLS +: WLS] = st;
    tick();
    wr_lvl_states_i = '0;
    m_lvl[k] = st;
  endtask

  task automatic read_slot(input logic [NC-1:0] sel);
    rd_carray_i = sel;
    tick();
    rd_carray_i = '0;
  endtask

  function automatic logic [WV-1:0] vstate(input logic [1:0] val, input logic [15:0] lvl);
    return {val, 1'b0, lvl};
  endfunction

  function automatic logic [WV*NV-1:0] exp_vars();
    logic [WV*NV-1:0] r;
    for (int k = 0; k < NV; k++) r[k*WV +: WV] = m_var[k];
    return r;
  endfunction

  function automatic logic [WLS*NL-1:0] exp_lvls();
    logic [WLS*NL-1:0] r;
    for (int k = 0; k < NL; k++) r[k*WLS +: WLS] = m_lvl[k];
    return r;
  endfunction

  // Count present / true / false literals per clause and apply the bin rules
  function automatic void model_eval(output logic sat, output logic unsat);
    logic all_sat, any_unsat;
    logic [1:0] lit, val;
    int np, nt, nf;
    all_sat = 1'b1; any_unsat = 1'b0;
    for (int c = 0; c < NC; c++) begin
      np = 0; nt = 0; nf = 0;
      for (int v = 0; v < NV; v++) begin
        lit = m_clause[c][2*v +: 2];
        val = m_var[v][WV-1 -: 2];
        if (lit == 2'd1 || lit == 2'd2) begin
          np++;
          if (lit == val) nt++;
          else if (val != 2'd0) nf++;
        end
      end
      if (np > 0 && nt == 0) all_sat = 1'b0;
      if (np > 0 && nf == np) any_unsat = 1'b1;
    end
    sat = all_sat & ~any_unsat;
    unsat = any_unsat;
  endfunction

  // Pulse start, watch 20 cycles; optionally poke start and writes mid-scan
  task automatic run_eval(input bit disturb, output int first_done, output int pulses);
    first_done = -1; pulses = 0;
    start_core_i = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) begin
        start_core_i = 1'b0;
        cur_bin_num_i = WB'($urandom); cur_lvl_i = WL'($urandom);
      end
      if (disturb && n == 3) begin
        start_core_i = 1'b1;
        wr_carray_i = 8'h02; clause_i = 16'hFFFF;
        wr_var_states_i = '1; vars_states_i = '1;
        wr_lvl_states_i = '1; lvl_states_i = '1;
      end
      if (disturb && n == 4) begin
        start_core_i = 1'b0; wr_carray_i = '0;
        wr_var_states_i = '0; wr_lvl_states_i = '0;
      end
      if (done_core_o) begin
        pulses++;
        if (first_done < 0) first_done = n;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    n_checks++;
    if ({done_core_o, local_sat_o, local_unsat_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {done_core_o, local_sat_o, local_unsat_o});
    end
    n_checks++;
    if ({cur_lvl_o, bkt_bin_o, bkt_lvl_o, base_lvl_o, clause_o} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got %h expected 0", {cur_lvl_o, bkt_bin_o, bkt_lvl_o, base_lvl_o, clause_o});
    end
    n_checks++;
    if ({vars_states_o, lvl_states_o} !== '0) begin
      n_fail++; $display("FAIL reset_storage: got %h expected 0", {vars_states_o, lvl_states_o});
    end
    @(negedge clk) rst = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_load_readback();
    put_clause(8'h08, 16'h0009);
    put_clause(8'h20, 16'h8001);
    read_slot(8'h28);
    n_checks++;
    if (clause_o !== 16'h0009) begin
      n_fail++; $display("FAIL read_lowest: got %h expected 0009", clause_o);
    end
    tick();
    n_checks++;
    if (clause_o !== 16'h0009) begin
      n_fail++; $display("FAIL read_hold: got %h expected 0009", clause_o);
    end
    read_slot(8'h20);
    n_checks++;
    if (clause_o !== 16'h8001) begin
      n_fail++; $display("FAIL read_slot5: got %h expected 8001", clause_o);
    end
    rd_carray_i = 8'h08; wr_carray_i = 8'h08; clause_i = 16'h1234;
    tick();
    rd_carray_i = '0; wr_carray_i = '0; m_clause[3] = 16'h1234;
    n_checks++;
    if (clause_o !== 16'h0009) begin
      n_fail++; $display("FAIL read_during_write: got %h expected 0009", clause_o);
    end
    read_slot(8'h08);
    n_checks++;
    if (clause_o !== 16'h1234) begin
      n_fail++; $display("FAIL read_after_write: got %h expected 1234", clause_o);
    end
    put_var(2, WV'($urandom));
    put_lvl(6, WLS'($urandom));
    n_checks++;
    if (vars_states_o !== exp_vars() || lvl_states_o !== exp_lvls()) begin
      n_fail++; $display("FAIL state_readback: got %h/%h expected %h/%h", vars_states_o, lvl_states_o, exp_vars(), exp_lvls());
    end
  endtask

  task automatic check_result(input string name, input logic esat, input logic eunsat,
                              input int first_done, input int pulses);
    n_checks++;
    if (first_done !== 9 || pulses !== 1) begin
      n_fail++; $display("FAIL %s_done: got latency %0d pulses %0d expected 9 and 1", name, first_done, pulses);
    end
    n_checks++;
    if ({local_sat_o, local_unsat_o} !== {esat, eunsat}) begin
      n_fail++; $display("FAIL %s_result: got sat/unsat %b%b expected %b%b", name, local_sat_o, local_unsat_o, esat, eunsat);
    end
  endtask

  task automatic test_sat();
    int fd, np;
    put_clause(8'hFF, 16'h0000);
    put_clause(8'h01, 16'h0002);
    put_var(0, vstate(2'b10, 16'd1));
    run_eval(1'b0, fd, np);
    check_result("sat", 1'b1, 1'b0, fd, np);
  endtask

  task automatic test_unsat();
    int fd, np;
    put_clause(8'h04, 16'h0004);
    put_var(1, vstate(2'b10, 16'd2));
    run_eval(1'b0, fd, np);
    check_result("unsat", 1'b0, 1'b1, fd, np);
  endtask

  task automatic test_undecided();
    int fd, np;
    put_clause(8'hFF, 16'h0000);
    put_clause(8'h01, 16'h0002);
    put_var(0, vstate(2'b00, 16'd0));
    cur_bin_num_i = 10'd7; cur_lvl_i = 16'd3;
    run_eval(1'b0, fd, np);
    check_result("undecided", 1'b0, 1'b0, fd, np);
    n_checks++;
    if (bkt_bin_o !== 10'd7 || bkt_lvl_o !== 16'd3 || cur_lvl_o !== 16'd3) begin
      n_fail++; $display("FAIL start_latch: got bin %0d lvl %0d cur %0d expected 7 3 3", bkt_bin_o, bkt_lvl_o, cur_lvl_o);
    end
  endtask

  task automatic test_all_empty();
    int fd, np;
    put_clause(8'hFF, 16'h0000);
    run_eval(1'b0, fd, np);
    check_result("all_empty", 1'b1, 1'b0, fd, np);
  endtask

  task automatic test_protocol();
    int fd, np;
    logic esat, eunsat;
    put_clause(8'h02, 16'h0010);
    model_eval(esat, eunsat);
    run_eval(1'b1, fd, np);
    check_result("protocol", esat, eunsat, fd, np);
    read_slot(8'h02);
    n_checks++;
    if (clause_o !== m_clause[1]) begin
      n_fail++; $display("FAIL eval_write_ignored: got %h expected %h", clause_o, m_clause[1]);
    end
    n_checks++;
    if (vars_states_o !== exp_vars() || lvl_states_o !== exp_lvls()) begin
      n_fail++; $display("FAIL eval_state_ignored: got %h/%h expected %h/%h", vars_states_o, lvl_states_o, exp_vars(), exp_lvls());
    end
  endtask

  task automatic test_base_lvl();
    base_lvl_en_i = 1'b1; base_lvl_i = 16'd5;
    tick();
    base_lvl_en_i = 1'b0; base_lvl_i = 16'd9;
    n_checks++;
    if (base_lvl_o !== 16'd5) begin
      n_fail++; $display("FAIL base_lvl_load: got %0d expected 5", base_lvl_o);
    end
    tick();
    n_checks++;
    if (base_lvl_o !== 16'd5) begin
      n_fail++; $display("FAIL base_lvl_hold: got %0d expected 5", base_lvl_o);
    end
  endtask

  task automatic test_random();
    int fd, np, slot;
    logic esat, eunsat;
    logic [2*NV-1:0] d;
    logic [WB-1:0] ebin;
    logic [WL-1:0] elvl;
    int r;
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < NC; c++) begin
        d = '0;
        if ($urandom_range(0, 9) >= 3) begin
          for (int v = 0; v < NV; v++) begin
            r = int'($urandom_range(0, 19));
            d[2*v +: 2] = (r < 14) ? 2'd0 : (r < 16) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
          end
        end
        if (it % 5 == 0 && c == 0) put_clause(8'hFF, d);
        else put_clause(NC'(1) << c, d);
      end
      for (int v = 0; v < NV; v++)
        put_var(v, vstate(2'($urandom_range(0, 2)), 16'($urandom)));
      put_lvl(int'($urandom_range(0, NL - 1)), WLS'($urandom));
      ebin = WB'($urandom); elvl = WL'($urandom);
      cur_bin_num_i = ebin; cur_lvl_i = elvl;
      model_eval(esat, eunsat);
      run_eval(1'b0, fd, np);
      check_result("random", esat, eunsat, fd, np);
      n_checks++;
      if (bkt_bin_o !== ebin || bkt_lvl_o !== elvl || cur_lvl_o !== elvl) begin
        n_fail++; $display("FAIL random_latch: got %h %h %h expected %h %h", bkt_bin_o, bkt_lvl_o, cur_lvl_o, ebin, elvl);
      end
      n_checks++;
      if (vars_states_o !== exp_vars() || lvl_states_o !== exp_lvls()) begin
        n_fail++; $display("FAIL random_states: got %h/%h expected %h/%h", vars_states_o, lvl_states_o, exp_vars(), exp_lvls());
      end
      slot = int'($urandom_range(0, NC - 1));
      read_slot(NC'(1) << slot);
      n_checks++;
      if (clause_o !== m_clause[slot]) begin
        n_fail++; $display("FAIL random_read slot %0d: got %h expected %h", slot, clause_o, m_clause[slot]);
      end
    end
  endtask

  task automatic test_reset_mid_eval();
    int fd, np, pulses;
    put_clause(8'hFF, 16'h0000);
    put_clause(8'h01, 16'h0002);
    put_var(0, vstate(2'b10, 16'd4));
    cur_bin_num_i = 10'h155; cur_lvl_i = 16'hBEEF;
    start_core_i = 1'b1;
    tick();
    start_core_i = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({done_core_o, local_sat_o, local_unsat_o, bkt_bin_o, bkt_lvl_o, cur_lvl_o} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {done_core_o, local_sat_o, local_unsat_o, bkt_bin_o, bkt_lvl_o, cur_lvl_o});
    end
    n_checks++;
    if ({vars_states_o, lvl_states_o, clause_o} !== '0) begin
      n_fail++; $display("FAIL midreset_storage: got %h expected 0", {vars_states_o, lvl_states_o, clause_o});
    end
    model_clear();
    @(negedge clk) rst = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done_core_o) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", pulses);
    end
    read_slot(8'h01);
    n_checks++;
    if (clause_o !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_cleared_slot: got %h expected 0000", clause_o);
    end
    put_clause(8'h01, 16'h0002);
    put_var(0, vstate(2'b10, 16'd4));
    run_eval(1'b0, fd, np);
    check_result("after_reset", 1'b1, 1'b0, fd, np);
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_sat();
    test_unsat();
    test_undecided();
    test_all_empty();
    test_protocol();
    test_base_lvl();
    test_random();
    test_reset_mid_eval();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sat_core_bin_port.md
Name: sat_core_bin_port

Overview:
- Core-side endpoint of the bin_manager load/update interface.
- Holds one bin in local storage: 8 clauses, 8 var states and 8 lvl states. bin_manager writes the bin in and reads it back; clause reads are per slot, state reads are whole-array.
- On start_core_i, scans the stored clauses against the var states, then reports local_sat/local_unsat with a done_core_o pulse.
- Serves as the SAT-engine stand-in for bin_manager system benches and as the storage front end of the real core.

Parameters:
- NUM_CLAUSES_A_BIN, 8, clause slots per bin
- NUM_VARS_A_BIN, 8, vars per bin; clause width is 2*NUM_VARS_A_BIN
- NUM_LVLS_A_BIN, 8, lvl slots per bin
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_LVL, 16, decision level width
- WIDTH_VAR_STATES, 19, {value[1:0], implied, level[15:0]}
- WIDTH_LVL_STATES, 11, {dcd_bin[9:0], has_bkt}

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start_core_i  in  1  start evaluation (one-cycle pulse)
- done_core_o  out  1  evaluation done, one-cycle pulse
- cur_bin_num_i  in  WIDTH_BIN_ID  bin being loaded
- cur_lvl_i  in  WIDTH_LVL  current level from bin_manager
- local_sat_o  out  1  all non-empty clauses satisfied
- local_unsat_o  out  1  some non-empty clause falsified
- cur_lvl_o  out  WIDTH_LVL  level latched at start
- bkt_bin_o  out  WIDTH_BIN_ID  bin id latched at start
- bkt_lvl_o  out  WIDTH_LVL  level latched at start
- wr_carray_i  in  NUM_CLAUSES_A_BIN  one-hot-or-more clause write enables
- rd_carray_i  in  NUM_CLAUSES_A_BIN  clause read select
- clause_i  in  2*NUM_VARS_A_BIN  clause write data
- clause_o  out  2*NUM_VARS_A_BIN  clause read data
- wr_var_states_i  in  NUM_VARS_A_BIN  per-var write enables
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS_A_BIN  var state write data
- vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS_A_BIN  stored var states
- wr_lvl_states_i  in  NUM_LVLS_A_BIN  per-lvl write enables
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  lvl state write data
- lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  stored lvl states
- base_lvl_en_i  in  1  base level load strobe
- base_lvl_i  in  WIDTH_LVL  base level value
- base_lvl_o  out  WIDTH_LVL  latched base level

Behaviour:
- Reset (rst=0, async):
  - All storage cleared to 0.
  - All outputs 0; FSM enters IDLE.
  - Reset mid-EVAL aborts the scan; no done pulse is issued.
- Encodings:
  - Literal 2 bits per var: 00 absent, 01 negative, 10 positive, 11 illegal (treated as absent).
  - Var value: 00 free, 01 false, 10 true.
  - A literal is true when lit==value; it is false when value!=00 and lit!=value.
- Writes (state IDLE only; ignored in EVAL/DONE):
  - Every set bit of wr_carray_i writes clause_i to that slot (broadcast allowed).
  - wr_var_states_i[k] writes slice k of vars_states_i; wr_lvl_states_i works the same way for lvl states.
  - Write data is visible on the outputs the next cycle.
- Clause read:
  - If rd_carray_i!=0, clause_o <= the slot of the lowest set bit, valid 1 cycle later.
  - If rd_carray_i==0, clause_o holds its value.
  - Read and write to the same slot in one cycle returns the old data.
  - Reads are allowed in any state.
- vars_states_o and lvl_states_o are the stored arrays directly (registered, no extra latency).
- base_lvl_o <= base_lvl_i when base_lvl_en_i is high, in any state.
- FSM:
  - IDLE: on start_core_i, latch cur_lvl_i into cur_lvl_o and bkt_lvl_o, latch cur_bin_num_i into bkt_bin_o, clear sat/unsat, idx=0, go to EVAL.
  - EVAL: one clause per cycle, idx 0..NUM_CLAUSES_A_BIN-1.
    - Empty clause (all literals absent) is skipped.
    - A non-empty clause with no true literal clears sat_acc.
    - A non-empty clause whose every present literal is false sets unsat_acc.
    - sat_acc starts at 1, unsat_acc at 0.
    - Go to DONE after idx=NUM_CLAUSES_A_BIN-1, with no wrap.
  - DONE (one cycle): done_core_o=1, local_sat_o=sat_acc&~unsat_acc, local_unsat_o=unsat_acc; go to IDLE.
- Latency: start to done pulse is NUM_CLAUSES_A_BIN+1 cycles (9).
- local_sat_o and local_unsat_o are held until the next start.
- start_core_i outside IDLE is ignored.
- A bin with all clauses empty reports sat=1, unsat=0.

Decomposition:
- Package sat_bin_pkg holds:
  - lit/value encoding constants (LIT_ABSENT, LIT_NEG, LIT_POS, VAL_FREE, VAL_FALSE, VAL_TRUE);
  - field offsets of the var state and lvl state;
  - FSM state enum {IDLE, EVAL, DONE}.
- One sub-module, clause_eval: combinational, takes one clause plus the value vector and returns {is_empty, is_sat, is_unsat}. Reused by the real core.

Test Plan:
- Load then read back: write slot 3 with 16'h0009 and slot 5 with 16'h8001, then rd_carray_i=8'h28 -> clause_o=16'h0009 on the next cycle.
- SAT case: clause0 = x0 positive (16'h0002), var0 value 10, other clauses empty, start -> done at cycle +9, local_sat_o=1, local_unsat_o=0.
- UNSAT case: clause2 = x1 negative (16'h0004), var1 value 10 -> local_unsat_o=1, local_sat_o=0.
- Undecided case: clause0 = x0 positive, var0 free -> done pulse with sat=0, unsat=0. bkt_bin_o=cur_bin_num_i=10'd7 and bkt_lvl_o=16'd3, both latched at start.
- Protocol: a write during EVAL is ignored on readback, and a second start during EVAL is ignored (exactly one done pulse). base_lvl_en_i with 16'd5 -> base_lvl_o=5.
- Reset at the 4th EVAL cycle -> no done pulse, all outputs 0, storage cleared; a following load and start complete normally.
